// File: rtl/sp_ram_march_pkg.sv
// sp_ram_march_pkg
//   Shared types and per-element lookups for the March C- RAM self-test
//   initiator (sp_ram_march).
//   - state_t : FSM states, one per March element plus IDLE and DRAIN
//   - phase_t : read/write sub-step inside the (r, w) elements M1..M4
//   - BG0/BG1 : background bit patterns; the top replicates them to the
//               data width so the package stays width-independent.
//   - elem_*  : per-element direction, expected read pattern, write
//               pattern and successor element.
package sp_ram_march_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M0    = 3'd1,
        M1    = 3'd2,
        M2    = 3'd3,
        M3    = 3'd4,
        M4    = 3'd5,
        M5    = 3'd6,
        DRAIN = 3'd7
    } state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } phase_t;

    // Replicated to DATA_WIDTH: BG0 -> '0, BG1 -> '1.
    localparam logic BG0 = 1'b0;
    localparam logic BG1 = 1'b1;

    // Descending address order (WORDS-1 down to 0).
    function automatic logic elem_desc(state_t s);
        return (s == M3) || (s == M4);
    endfunction

    // Pattern a read of this element must return.
    function automatic logic elem_rd_bg(state_t s);
        return ((s == M2) || (s == M4)) ? BG1 : BG0;
    endfunction

    // Pattern this element writes.
    function automatic logic elem_wr_bg(state_t s);
        return ((s == M1) || (s == M3)) ? BG1 : BG0;
    endfunction

    // Elements made of a read followed by a write to the same word.
    function automatic logic elem_is_rw(state_t s);
        return (s == M1) || (s == M2) || (s == M3) || (s == M4);
    endfunction

    function automatic state_t elem_next(state_t s);
        case (s)
            M0:      return M1;
            M1:      return M2;
            M2:      return M3;
            M3:      return M4;
            M4:      return M5;
            M5:      return DRAIN;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sp_ram_march.sv
// sp_ram_march
//   March C- built-in self-test initiator for the single-port RAM wrapper.
//   Runs {w0 up; (r0,w1) up; (r1,w0) up; (r0,w1) down; (r1,w0) down; r0 up}
//   over every word and reports pass/fail plus the first failing address.
//
//   Optional build macro: SP_RAM_MARCH_ABORT_EN
//     defined   : first mismatch sends the FSM straight to IDLE (done+fail).
//     undefined : always runs to completion; run length is fault-independent.
//
//   Ports
//     clk, rstn_i        clock, async active-low reset
//     start_i            start request, sampled only in IDLE
//     busy_o             test running (selects this port in front of the core)
//     done_o, fail_o     sticky status since the last start
//     fail_addr_o        byte address of the first mismatch
//     ram_en_o .. be_o   request to the RAM wrapper
//     ram_rdata_i        read data, one cycle after the read request
//
//   state | meaning
//   IDLE  | waiting for start_i
//   M0    | ascending w0, one word per cycle
//   M1    | ascending (r0, w1)
//   M2    | ascending (r1, w0)
//   M3    | descending (r0, w1)
//   M4    | descending (r1, w0)
//   M5    | ascending r0, compare pipelined one cycle behind
//   DRAIN | no request; compares the final M5 read
module sp_ram_march
    import sp_ram_march_pkg::*;
#(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fail_o,
    output logic [ADDR_WIDTH-1:0]     fail_addr_o,
    output logic                      ram_en_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    output logic                      ram_we_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

    localparam int WORDS = RAM_SIZE / 4;
    localparam int CW    = ADDR_WIDTH - 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);

    state_t                  state_q, state_d;
    phase_t                  phase_q, phase_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;
    logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
    // M5 reads are checked one cycle later, so remember which word was read.
    logic                    cmp_valid_q, cmp_valid_d;
    logic [CW-1:0]           cmp_word_q, cmp_word_d;

    logic                    at_last;
    logic [CW-1:0]           cnt_step;
    logic [CW-1:0]           cnt_first_next;
    state_t                  elem_nxt;
    logic                    chk_rw;
    logic                    chk_m5;
    logic                    mismatch;
    logic [ADDR_WIDTH-1:0]   chk_addr;
    logic [DATA_WIDTH-1:0]   exp_word;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            phase_q     <= RD;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            cmp_valid_q <= 1'b0;
            cmp_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_word_q  <= cmp_word_d;
        end
    end

    // Compare: in the write cycle of M1..M4 the data returned is for the read
    // just issued to the same word; in M5/DRAIN it is the previous M5 read.
    always_comb begin
        chk_rw   = elem_is_rw(state_q) && (phase_q == WR);
        chk_m5   = ((state_q == M5) || (state_q == DRAIN)) && cmp_valid_q;
        exp_word = {DATA_WIDTH{elem_rd_bg(state_q)}};
        chk_addr = chk_rw ? {cnt_q, 2'b00} : {cmp_word_q, 2'b00};
        mismatch = (chk_rw || chk_m5) && (ram_rdata_i != exp_word);
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        cmp_valid_d = (state_q == M5);
        cmp_word_d  = cnt_q;

        at_last        = elem_desc(state_q) ? (cnt_q == '0) : (cnt_q == CNT_LAST);
        cnt_step       = elem_desc(state_q) ? (cnt_q - CW'(1)) : (cnt_q + CW'(1));
        elem_nxt       = elem_next(state_q);
        cnt_first_next = elem_desc(elem_nxt) ? CNT_LAST : '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = M0;
                    phase_d     = RD;
                    cnt_d       = '0;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                end
            end
            M0, M5: begin
                if (at_last) begin
                    state_d = elem_nxt;
                    phase_d = RD;
                    cnt_d   = cnt_first_next;
                end else begin
                    cnt_d = cnt_step;
                end
            end
            M1, M2, M3, M4: begin
                if (phase_q == RD) begin
                    phase_d = WR;
                end else begin
                    phase_d = RD;
                    if (at_last) begin
                        state_d = elem_nxt;
                        cnt_d   = cnt_first_next;
                    end else begin
                        cnt_d = cnt_step;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (mismatch && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = chk_addr;
        end

`ifdef SP_RAM_MARCH_ABORT_EN
        // Any mismatch here is the first one: the run stops on this edge.
        if (mismatch) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
`endif
    end

    // Request signals decode straight from state so an async reset drops
    // them without waiting for a clock edge.
    always_comb begin
        busy_o      = (state_q != IDLE);
        ram_en_o    = (state_q != IDLE) && (state_q != DRAIN);
        ram_we_o    = (state_q == M0) || (elem_is_rw(state_q) && (phase_q == WR));
        ram_addr_o  = {cnt_q, 2'b00};
        ram_wdata_o = ram_we_o ? {DATA_WIDTH{elem_wr_bg(state_q)}} : '0;
        ram_be_o    = {(DATA_WIDTH/8){ram_en_o}};
        done_o      = done_q;
        fail_o      = fail_q;
        fail_addr_o = fail_addr_q;
    end

endmodule

// File: tb/tb_sp_ram_march.sv
module tb_sp_ram_march;

    localparam int AW = 6;
    localparam int DW = 32;

`ifdef SP_RAM_MARCH_ABORT_EN
    localparam int LEN_SA = 28;   // abort at M1 word-5 compare (busy cycle 27)
    localparam int LEN_CF = 36;   // abort at M1 word-9 compare (busy cycle 35)
    localparam int PULSE_AT = 10;
`else
    localparam int LEN_SA = 161;
    localparam int LEN_CF = 161;
    localparam int PULSE_AT = 50;
`endif

    logic            clk = 1'b0;
    logic            rstn_i;
    logic            start_i;
    logic            busy_o, done_o, fail_o;
    logic [AW-1:0]   fail_addr_o;
    logic            ram_en_o, ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [DW-1:0]   ram_wdata_o;
    logic [3:0]      ram_be_o;
    logic [DW-1:0]   ram_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic            fault_sa = 1'b0;
    logic            fault_cf = 1'b0;
    logic [DW-1:0]   mem [0:15];

    int wr_total = 0, rd_total = 0, proto_err = 0, run_idx = 0;
    logic prev_busy = 1'b0;
    logic [AW-1:0] addr_log [0:255];
    logic          we_log   [0:255];

    sp_ram_march #(.RAM_SIZE(64), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn_i(rstn_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_addr_o(fail_addr_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    // Behavioural 1-cycle RAM with optional stuck-at and coupling faults.
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                mem[ram_addr_o[5:2]] <= ram_wdata_o;
                if (fault_cf && ram_addr_o[5:2] == 4'd2 && ram_wdata_o == '1)
                    mem[9] <= ~mem[9];
            end else begin
                ram_rdata_i <= mem[ram_addr_o[5:2]] |
                               ((fault_sa && ram_addr_o[5:2] == 4'd5) ? 32'h8 : 32'h0);
            end
        end
    end

    // Request log and protocol observation.
    always @(negedge clk) begin
        if (busy_o) begin
            if (!prev_busy) run_idx = 0;
            if (run_idx < 256) begin
                addr_log[run_idx] = ram_addr_o;
                we_log[run_idx]   = ram_we_o;
            end
            run_idx++;
        end
        prev_busy = busy_o;
        if (ram_en_o) begin
            if (ram_we_o) wr_total++; else rd_total++;
        end
        if (ram_en_o && ram_be_o !== 4'hF) proto_err++;
        if (!ram_en_o && ram_be_o !== 4'h0) proto_err++;
        if (!ram_we_o && ram_wdata_o !== '0) proto_err++;
        if (ram_addr_o[1:0] !== 2'b00) proto_err++;
    end

    task automatic start_pulse();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    // Counts negedges with busy_o high until it falls; -1 on timeout.
    task automatic run_measure(output int len);
        int cnt = 0;
        bit ended = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy_o) cnt++;
            else if (cnt > 0) begin ended = 1; break; end
        end
        len = ended ? cnt : -1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; start_i = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy_o, done_o, fail_o, ram_en_o, ram_we_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b exp 00000", {busy_o, done_o, fail_o, ram_en_o, ram_we_o});
        end
        n_tests++;
        if ({fail_addr_o, ram_addr_o, ram_wdata_o, ram_be_o} !== '0) begin
            n_fail++; $display("FAIL reset_bus: got %h/%h/%h/%h exp 0", fail_addr_o, ram_addr_o, ram_wdata_o, ram_be_o);
        end
        @(posedge clk); #1 rstn_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fault_free();
        int len, w0, r0, errs;
        w0 = wr_total; r0 = rd_total;
        start_pulse();
        run_measure(len);
        n_tests++;
        if (len !== 161) begin n_fail++; $display("FAIL ff_len: got %0d exp 161", len); end
        n_tests++;
        if (done_o !== 1'b1 || fail_o !== 1'b0) begin
            n_fail++; $display("FAIL ff_status: done=%b fail=%b exp done=1 fail=0", done_o, fail_o);
        end
        n_tests++;
        if (wr_total - w0 !== 80) begin n_fail++; $display("FAIL ff_writes: got %0d exp 80", wr_total - w0); end
        n_tests++;
        if (rd_total - r0 !== 80) begin n_fail++; $display("FAIL ff_reads: got %0d exp 80", rd_total - r0); end
        // M3 occupies busy cycles 80..111: word 15 down to 0, read then write.
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            if (addr_log[80 + i] !== AW'((15 - i / 2) * 4)) errs++;
            if (we_log[80 + i] !== logic'(i % 2)) errs++;
        end
        n_tests++;
        if (errs !== 0) begin n_fail++; $display("FAIL ff_m3_order: %0d bad entries exp 0", errs); end
    endtask

    task automatic test_stuck_at();
        int len;
        fault_sa = 1'b1;
        start_pulse();
        run_measure(len);
        n_tests++;
        if (len !== LEN_SA) begin n_fail++; $display("FAIL sa_len: got %0d exp %0d", len, LEN_SA); end
        n_tests++;
        if (done_o !== 1'b1 || fail_o !== 1'b1 || fail_addr_o !== 6'h14) begin
            n_fail++; $display("FAIL sa_status: done=%b fail=%b addr=%h exp 1 1 14", done_o, fail_o, fail_addr_o);
        end
        n_tests++;
        if (ram_en_o !== 1'b0) begin n_fail++; $display("FAIL sa_en_after: got %b exp 0", ram_en_o); end
        fault_sa = 1'b0;
    endtask

    task automatic test_coupling();
        int len;
        fault_cf = 1'b1;
        start_pulse();
        run_measure(len);
        n_tests++;
        if (len !== LEN_CF) begin n_fail++; $display("FAIL cf_len: got %0d exp %0d", len, LEN_CF); end
        n_tests++;
        if (done_o !== 1'b1 || fail_o !== 1'b1 || fail_addr_o !== 6'h24) begin
            n_fail++; $display("FAIL cf_status: done=%b fail=%b addr=%h exp 1 1 24", done_o, fail_o, fail_addr_o);
        end
        fault_cf = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cnt = 0, len;
        start_pulse();
        for (int i = 0; i < 100 && cnt < 40; i++) begin
            @(negedge clk);
            if (busy_o) cnt++;
        end
        @(posedge clk); #1 rstn_i = 1'b0;
        #1;
        n_tests++;
        if (ram_en_o !== 1'b0 || busy_o !== 1'b0 || ram_we_o !== 1'b0) begin
            n_fail++; $display("FAIL rm_async_drop: en=%b busy=%b we=%b exp 0 0 0", ram_en_o, busy_o, ram_we_o);
        end
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy_o, done_o, fail_o, ram_en_o, fail_addr_o, ram_addr_o} !== '0) begin
            n_fail++; $display("FAIL rm_after: busy=%b done=%b fail=%b en=%b fa=%h addr=%h exp all 0",
                               busy_o, done_o, fail_o, ram_en_o, fail_addr_o, ram_addr_o);
        end
        start_pulse();
        run_measure(len);
        n_tests++;
        if (len !== 161 || done_o !== 1'b1) begin
            n_fail++; $display("FAIL rm_rerun: len=%0d done=%b exp 161 1", len, done_o);
        end
    endtask

    task automatic test_back_to_back();
        int len1, len2;
        @(posedge clk); #1 start_i = 1'b1;
        run_measure(len1);
        n_tests++;
        if (len1 !== 161 || done_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: len=%0d done=%b exp 161 1", len1, done_o);
        end
        @(negedge clk);
        n_tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_restart: done=%b busy=%b exp 0 1", done_o, busy_o);
        end
        start_i = 1'b0;
        run_measure(len2);
        // One busy cycle of the second run was already consumed above.
        n_tests++;
        if (len2 + 1 !== 161 || done_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: len=%0d done=%b exp 161 1", len2 + 1, done_o);
        end
    endtask

    task automatic test_start_while_busy();
        int cnt = 0;
        bit ended = 0;
        fault_sa = 1'b1;
        start_pulse();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy_o) begin
                cnt++;
                if (cnt == PULSE_AT) start_i = 1'b1;
                if (cnt == PULSE_AT + 1) begin
                    start_i = 1'b0;
`ifndef SP_RAM_MARCH_ABORT_EN
                    n_tests++;
                    if (fail_o !== 1'b1 || fail_addr_o !== 6'h14) begin
                        n_fail++; $display("FAIL swb_kept: fail=%b addr=%h exp 1 14", fail_o, fail_addr_o);
                    end
`endif
                end
            end else if (cnt > 0) begin
                ended = 1; break;
            end
        end
        n_tests++;
        if (!ended || cnt !== LEN_SA) begin n_fail++; $display("FAIL swb_len: got %0d exp %0d", cnt, LEN_SA); end
        n_tests++;
        if (done_o !== 1'b1 || fail_o !== 1'b1 || fail_addr_o !== 6'h14) begin
            n_fail++; $display("FAIL swb_status: done=%b fail=%b addr=%h exp 1 1 14", done_o, fail_o, fail_addr_o);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL swb_no_restart: busy=%b exp 0", busy_o); end
        fault_sa = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_coupling();
        test_reset_mid();
        test_back_to_back();
        test_start_while_busy();
        n_tests++;
        if (proto_err !== 0) begin n_fail++; $display("FAIL protocol: %0d violations exp 0", proto_err); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
